// File: rtl/net_write_tracker_pkg.sv
// Shared types, limits and helpers for the multi-channel net-write tracker.
package net_write_tracker_pkg;

   localparam int CNT_W           = 64;
   localparam int MAX_SYNC_STAGES = 8;

   typedef logic signed [CNT_W-1:0] count_t;

   // Caller sets eq_vec[k] = (stage k == stage 0) and ties unused stages to 1,
   // so the chain is stable exactly when every bit is set.
   function automatic logic chain_stable(input logic [MAX_SYNC_STAGES-1:0] eq_vec);
      return &eq_vec;
   endfunction

   function automatic bit sync_stages_ok(input int n);
      return (n >= 2) && (n <= MAX_SYNC_STAGES);
   endfunction

   function automatic bit stale_limit_ok(input int n);
      return n >= 1;
   endfunction

endpackage

// File: rtl/net_write_tracker_chan.sv
// One channel: read-count stability chain, last stable reads, occupancy,
// full/almost-full flags, stale detection and sticky range error.
module net_write_tracker_chan
   import net_write_tracker_pkg::*;
#(
   parameter int DWIDTH      = 64,
   parameter int SYNC_STAGES = 3,
   parameter int FIFO_DEPTH  = 1024,
   parameter int AF_MARGIN   = 4,
   parameter int STALE_LIMIT = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DWIDTH-1:0] writes_i,
   input  logic [DWIDTH-1:0] reads_i,
   input  logic              clear_err_i,
   output logic [DWIDTH-1:0] net_o,
   output logic              full_o,
   output logic              almost_full_o,
   output logic              stale_o,
   output logic              update_o,
   output logic              err_o
);

   if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync
      $error("SYNC_STAGES must be in 2..%0d", MAX_SYNC_STAGES);
   end
   if (!stale_limit_ok(STALE_LIMIT)) begin : g_bad_stale
      $error("STALE_LIMIT must be >= 1");
   end

   localparam int CW = $clog2(STALE_LIMIT + 1);
   localparam logic signed [DWIDTH-1:0] DEPTH_S = DWIDTH'(FIFO_DEPTH);
   localparam logic signed [DWIDTH-1:0] AF_S    = DWIDTH'(FIFO_DEPTH - AF_MARGIN);
   localparam logic [CW-1:0]            LIMIT_C = CW'(STALE_LIMIT);

   logic [SYNC_STAGES-1:0][DWIDTH-1:0] chain_q, chain_d;
   logic [DWIDTH-1:0]                  lsr_q, lsr_d;
   logic signed [DWIDTH-1:0]           net_q, net_d;
   logic [CW-1:0]                      cnt_q, cnt_d;
   logic full_q, full_d, af_q, af_d, stale_q, stale_d;
   logic upd_q, upd_d, err_q, err_d;
   logic [MAX_SYNC_STAGES-1:0]         eq_vec;
   logic                               stable;

   // Stage comparison against stage 0; stages beyond the chain count as equal.
   always_comb begin
      eq_vec = '1;
      for (int i = 1; i < SYNC_STAGES; i++) eq_vec[i] = (chain_q[i] == chain_q[0]);
   end

   assign stable = chain_stable(eq_vec);

   // Next state: chain shift, stable-read latch, occupancy, flags, stale and error.
   always_comb begin
      chain_d = {chain_q[SYNC_STAGES-2:0], reads_i};
      lsr_d   = stable ? chain_q[0] : lsr_q;
      upd_d   = stable && (chain_q[0] != lsr_q);
      // Uses the held reads value; modulo subtraction absorbs counter wrap.
      net_d   = $signed(writes_i - lsr_q);
      full_d  = (net_d >= DEPTH_S);
      af_d    = (net_d >= AF_S);
      if (stable)                cnt_d = '0;
      else if (cnt_q >= LIMIT_C) cnt_d = LIMIT_C;
      else                       cnt_d = cnt_q + 1'b1;
      stale_d = (cnt_d >= LIMIT_C);
      // A fresh violation beats a same-cycle clear.
      if ((net_d < 0) || (net_d > DEPTH_S)) err_d = 1'b1;
      else if (clear_err_i)                 err_d = 1'b0;
      else                                  err_d = err_q;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         chain_q <= '0;
         lsr_q   <= '0;
         net_q   <= '0;
         cnt_q   <= '0;
         full_q  <= 1'b0;
         af_q    <= 1'b0;
         stale_q <= 1'b0;
         upd_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         chain_q <= chain_d;
         lsr_q   <= lsr_d;
         net_q   <= net_d;
         cnt_q   <= cnt_d;
         full_q  <= full_d;
         af_q    <= af_d;
         stale_q <= stale_d;
         upd_q   <= upd_d;
         err_q   <= err_d;
      end
   end

   assign net_o         = net_q;
   assign full_o        = full_q;
   assign almost_full_o = af_q;
   assign stale_o       = stale_q;
   assign update_o      = upd_q;
   assign err_o         = err_q;

endmodule

// File: rtl/net_write_tracker_multi.sv
// Bank of independent net-write trackers; slices the flat buses per channel.
module net_write_tracker_multi
   import net_write_tracker_pkg::*;
#(
   parameter int DWIDTH      = 64,
   parameter int NUM_CH      = 4,
   parameter int SYNC_STAGES = 3,
   parameter int FIFO_DEPTH  = 1024,
   parameter int AF_MARGIN   = 4,
   parameter int STALE_LIMIT = 16
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic [NUM_CH*DWIDTH-1:0] total_writes,
   input  logic [NUM_CH*DWIDTH-1:0] total_reads,
   input  logic [NUM_CH-1:0]        clear_err,
   output logic [NUM_CH*DWIDTH-1:0] net_writes,
   output logic [NUM_CH-1:0]        full,
   output logic [NUM_CH-1:0]        almost_full,
   output logic [NUM_CH-1:0]        stale,
   output logic [NUM_CH-1:0]        reads_update,
   output logic [NUM_CH-1:0]        range_err
);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      net_write_tracker_chan #(
         .DWIDTH      (DWIDTH),
         .SYNC_STAGES (SYNC_STAGES),
         .FIFO_DEPTH  (FIFO_DEPTH),
         .AF_MARGIN   (AF_MARGIN),
         .STALE_LIMIT (STALE_LIMIT)
      ) u_chan (
         .clk_i         (aclk),
         .rst_i         (areset),
         .writes_i      (total_writes[c*DWIDTH +: DWIDTH]),
         .reads_i       (total_reads[c*DWIDTH +: DWIDTH]),
         .clear_err_i   (clear_err[c]),
         .net_o         (net_writes[c*DWIDTH +: DWIDTH]),
         .full_o        (full[c]),
         .almost_full_o (almost_full[c]),
         .stale_o       (stale[c]),
         .update_o      (reads_update[c]),
         .err_o         (range_err[c])
      );
   end

endmodule
